// File: rtl/vend_credit_encoder.sv
// vend_credit_encoder: coin credit accumulator with vend request/ack sequencing and change return
module vend_credit_encoder #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned MAX_CREDIT = 8,
  parameter int unsigned PRICE      = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             coin_valid,
  input  logic [2:0]       coin_value,
  output logic             coin_ready,
  input  logic             vend_req,
  output logic             vend_ack,
  output logic             vend_nack,
  output logic [WIDTH-1:0] credit_code,
  output logic             change_valid,
  output logic [WIDTH-1:0] change_amount,
  input  logic             change_ack
);
  typedef enum logic [1:0] {IDLE, VEND, NACK, CHANGE} state_t;
  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_CREDIT);
  localparam logic [WIDTH-1:0] PRC   = WIDTH'(PRICE);
  state_t state_q, state_d;
  logic [WIDTH-1:0] credit_q, credit_d, change_q, change_d;
  logic ready_q, ready_d;
  logic [WIDTH:0] sum;
  logic coin;
  always_comb begin
    coin     = coin_valid && coin_value != 3'd0;
    sum      = {1'b0, credit_q} + (WIDTH+1)'(coin_value);
    state_d  = state_q;
    credit_d = credit_q;
    change_d = change_q;
    case (state_q)
      IDLE:
        if (coin) begin
          credit_d = sum <= {1'b0, MAX_C} ? sum[WIDTH-1:0] : MAX_C;
          change_d = sum <= {1'b0, MAX_C} ? change_q : sum[WIDTH-1:0] - MAX_C;
          state_d  = sum <= {1'b0, MAX_C} ? IDLE : CHANGE;
        end else if (vend_req) begin
          state_d = credit_q >= PRC ? VEND : NACK;
        end
      VEND: begin
        // any remainder after the price leaves as change, so credit always clears
        credit_d = '0;
        change_d = credit_q - PRC;
        state_d  = credit_q != PRC ? CHANGE : IDLE;
      end
      NACK: state_d = IDLE;
      CHANGE:
        if (change_ack) begin
          change_d = '0;
          state_d  = IDLE;
        end
      default: state_d = IDLE;
    endcase
    ready_d = state_d == IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= IDLE;
      credit_q <= '0;
      change_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      change_q <= change_d;
      ready_q  <= ready_d;
    end
  assign coin_ready    = ready_q;
  assign vend_ack      = state_q == VEND;
  assign vend_nack     = state_q == NACK;
  assign change_valid  = state_q == CHANGE;
  assign credit_code   = credit_q;
  assign change_amount = change_q;
endmodule

// File: tb/tb_vend_credit_encoder.sv
// tb_vend_credit_encoder: directed scenario tests for the vending credit encoder
module tb_vend_credit_encoder;
  logic clk = 0, rst_n = 0, coin_valid = 0, vend_req = 0, change_ack = 0;
  logic [2:0] coin_value = 0;
  logic coin_ready, vend_ack, vend_nack, change_valid;
  logic [3:0] credit_code, change_amount;
  int pass = 0, tot = 0;
  vend_credit_encoder dut (
    .clk(clk), .rst_n(rst_n), .coin_valid(coin_valid), .coin_value(coin_value),
    .coin_ready(coin_ready), .vend_req(vend_req), .vend_ack(vend_ack), .vend_nack(vend_nack),
    .credit_code(credit_code), .change_valid(change_valid), .change_amount(change_amount),
    .change_ack(change_ack)
  );
  always #5 clk = ~clk;
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic coin(input logic [2:0] v);
    coin_valid = 1; coin_value = v;
    cyc();
    coin_valid = 0; coin_value = 0;
  endtask
  task automatic test_reset;
    rst_n = 0;
    #2;
    tot++; if (credit_code !== 4'd0) $display("FAIL reset_credit got %0d want 0", credit_code); else pass++;
    tot++; if ({coin_ready, vend_ack, vend_nack, change_valid} !== 4'b0) $display("FAIL reset_outs got %b want 0000", {coin_ready, vend_ack, vend_nack, change_valid}); else pass++;
    @(negedge clk); rst_n = 1;
    cyc();
    tot++; if (coin_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", coin_ready); else pass++;
  endtask
  task automatic test_coins;
    coin(2);
    tot++; if (credit_code !== 4'd2) $display("FAIL coin2 got %0d want 2", credit_code); else pass++;
    coin(3);
    tot++; if (credit_code !== 4'd5) $display("FAIL coin3 got %0d want 5", credit_code); else pass++;
    tot++; if (change_valid !== 1'b0) $display("FAIL coin_nochange got %b want 0", change_valid); else pass++;
  endtask
  task automatic test_vend_exact;
    vend_req = 1;
    cyc();
    tot++; if (vend_ack !== 1'b1 || coin_ready !== 1'b0) $display("FAIL vend_ack got ack=%b rdy=%b want 1,0", vend_ack, coin_ready); else pass++;
    vend_req = 0;
    cyc();
    tot++; if (credit_code !== 4'd0 || vend_ack !== 1'b0) $display("FAIL vend_after got credit=%0d ack=%b want 0,0", credit_code, vend_ack); else pass++;
    tot++; if (change_valid !== 1'b0 || coin_ready !== 1'b1) $display("FAIL vend_nochange got cv=%b rdy=%b want 0,1", change_valid, coin_ready); else pass++;
  endtask
  task automatic test_vend_change;
    coin(4); coin(3);
    tot++; if (credit_code !== 4'd7) $display("FAIL vc_credit got %0d want 7", credit_code); else pass++;
    vend_req = 1;
    cyc();
    tot++; if (vend_ack !== 1'b1) $display("FAIL vc_ack got %b want 1", vend_ack); else pass++;
    vend_req = 0;
    change_ack = 0;
    cyc();
    tot++; if (change_valid !== 1'b1 || change_amount !== 4'd2 || credit_code !== 4'd0) $display("FAIL vc_change got cv=%b amt=%0d credit=%0d want 1,2,0", change_valid, change_amount, credit_code); else pass++;
    cyc();
    tot++; if (change_valid !== 1'b1 || change_amount !== 4'd2) $display("FAIL vc_hold got cv=%b amt=%0d want 1,2", change_valid, change_amount); else pass++;
    change_ack = 1;
    cyc();
    change_ack = 0;
    tot++; if (change_valid !== 1'b0 || change_amount !== 4'd0 || coin_ready !== 1'b1) $display("FAIL vc_ack got cv=%b amt=%0d rdy=%b want 0,0,1", change_valid, change_amount, coin_ready); else pass++;
  endtask
  task automatic test_nack;
    coin(3);
    vend_req = 1;
    cyc();
    tot++; if (vend_nack !== 1'b1 || vend_ack !== 1'b0 || credit_code !== 4'd3) $display("FAIL nack got nack=%b ack=%b credit=%0d want 1,0,3", vend_nack, vend_ack, credit_code); else pass++;
    vend_req = 0;
    cyc();
    tot++; if (vend_nack !== 1'b0 || coin_ready !== 1'b1 || credit_code !== 4'd3) $display("FAIL nack_after got nack=%b rdy=%b credit=%0d want 0,1,3", vend_nack, coin_ready, credit_code); else pass++;
  endtask
  task automatic test_overflow;
    coin(3);
    tot++; if (credit_code !== 4'd6) $display("FAIL ov_pre got %0d want 6", credit_code); else pass++;
    coin(5);
    tot++; if (credit_code !== 4'd8 || change_amount !== 4'd3 || change_valid !== 1'b1 || coin_ready !== 1'b0) $display("FAIL ov_sat got credit=%0d amt=%0d cv=%b rdy=%b want 8,3,1,0", credit_code, change_amount, change_valid, coin_ready); else pass++;
    coin(1);
    tot++; if (credit_code !== 4'd8 || change_amount !== 4'd3 || coin_ready !== 1'b0) $display("FAIL ov_ignore got credit=%0d amt=%0d rdy=%b want 8,3,0", credit_code, change_amount, coin_ready); else pass++;
    change_ack = 1;
    cyc();
    tot++; if (coin_ready !== 1'b1 || change_valid !== 1'b0 || credit_code !== 4'd8) $display("FAIL ov_ack got rdy=%b cv=%b credit=%0d want 1,0,8", coin_ready, change_valid, credit_code); else pass++;
    cyc();
    change_ack = 0;
    tot++; if (change_valid !== 1'b0 || coin_ready !== 1'b1) $display("FAIL stray_ack got cv=%b rdy=%b want 0,1", change_valid, coin_ready); else pass++;
    coin(7);
    tot++; if (credit_code !== 4'd8 || change_amount !== 4'd7 || change_valid !== 1'b1) $display("FAIL ov_full got credit=%0d amt=%0d cv=%b want 8,7,1", credit_code, change_amount, change_valid); else pass++;
    change_ack = 1;
    cyc();
    change_ack = 0;
  endtask
  task automatic test_back_to_back;
    rst_n = 0;
    @(negedge clk); rst_n = 1;
    cyc();
    tot++; if (credit_code !== 4'd0) $display("FAIL b2b_reset got %0d want 0", credit_code); else pass++;
    vend_req = 1;
    coin(5);
    tot++; if (credit_code !== 4'd5 || vend_ack !== 1'b0 || vend_nack !== 1'b0) $display("FAIL b2b_coin got credit=%0d ack=%b nack=%b want 5,0,0", credit_code, vend_ack, vend_nack); else pass++;
    cyc();
    tot++; if (vend_ack !== 1'b1) $display("FAIL b2b_ack got %b want 1", vend_ack); else pass++;
    vend_req = 0;
    cyc();
    tot++; if (credit_code !== 4'd0) $display("FAIL b2b_credit got %0d want 0", credit_code); else pass++;
  endtask
  task automatic test_reset_in_change;
    coin(4); coin(4); coin(3);
    tot++; if (change_valid !== 1'b1 || change_amount !== 4'd3) $display("FAIL rc_pre got cv=%b amt=%0d want 1,3", change_valid, change_amount); else pass++;
    #2 rst_n = 0;
    #1;
    tot++; if ({change_valid, coin_ready, vend_ack, vend_nack} !== 4'b0 || change_amount !== 4'd0 || credit_code !== 4'd0) $display("FAIL rc_async got outs=%b amt=%0d credit=%0d want 0000,0,0", {change_valid, coin_ready, vend_ack, vend_nack}, change_amount, credit_code); else pass++;
    @(negedge clk); rst_n = 1;
    cyc();
    tot++; if (coin_ready !== 1'b1 || change_valid !== 1'b0 || credit_code !== 4'd0) $display("FAIL rc_after got rdy=%b cv=%b credit=%0d want 1,0,0", coin_ready, change_valid, credit_code); else pass++;
  endtask
  initial begin
    test_reset();
    test_coins();
    test_vend_exact();
    test_vend_change();
    test_nack();
    test_overflow();
    test_back_to_back();
    test_reset_in_change();
    $display("%0d/%0d checks passed", pass, tot);
    $finish;
  end
endmodule
